// File: rtl/python_align_pkg.sv
// Shared types and constants for the word-alignment training controller.
package python_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } align_state_t;

    localparam logic [9:0] DEFAULT_TRAIN_PATTERN = 10'h3A6;
    localparam logic [3:0] SLIP_CNT_SAT          = 4'd15;

endpackage

// File: rtl/python_align_word_cmp.sv
// Registered compare of the sync word and every data lane against the training word.
module python_align_word_cmp
    import python_align_pkg::*;
#(
    parameter int         CHANNELS      = 4,
    parameter logic [9:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [CHANNELS-1:0][9:0] i_data,
    input  logic [9:0]               i_sync,
    output logic                     o_sync_match,
    output logic [CHANNELS-1:0]      o_lane_match
);

    logic                r_sync_match;
    logic [CHANNELS-1:0] r_lane_match;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync_match <= 1'b0;
            r_lane_match <= '0;
        end else begin
            r_sync_match <= (i_sync == TRAIN_PATTERN);
            for (int i = 0; i < CHANNELS; i++) begin
                r_lane_match[i] <= (i_data[i] == TRAIN_PATTERN);
            end
        end
    end

    assign o_sync_match = r_sync_match;
    assign o_lane_match = r_lane_match;

endmodule

// File: rtl/python_align_training.sv
// Bitslip training FSM: slips the deserializer until MATCH_COUNT consecutive training words are seen.
// Optional per-lane data check enabled by defining PYTHON_ALIGN_DATA_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for enable, counters cleared on exit
// CHECK  | counting consecutive training-word matches
// SLIP   | one-cycle bitslip pulse to the deserializer
// WAIT   | SLIP_WAIT settle cycles, input ignored
// LOCKED | aligned, lane errors accumulate
// FAIL   | slip budget exhausted
module python_align_training
    import python_align_pkg::*;
#(
    parameter int         CHANNELS      = 4,
    parameter logic [9:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int         SLIP_WAIT     = 8,
    parameter int         MATCH_COUNT   = 16,
    parameter int         MAX_SLIP      = 10
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     enable,
    input  logic [CHANNELS-1:0][9:0] in_data,
    input  logic [9:0]               in_sync,
    output logic                     out_bitslip,
    output logic                     out_aligned,
    output logic                     out_error,
    output logic [3:0]               out_slip_count,
    output logic [CHANNELS-1:0]      out_ch_error
);

    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] WAIT_LOAD  = 8'(SLIP_WAIT - 1);

    align_state_t        r_state, w_next;
    logic [7:0]          r_match_cnt;
    logic [7:0]          r_wait_cnt;
    logic [3:0]          r_slip_cnt;
    logic                r_bitslip, r_aligned, r_error;
    logic                w_sync_match, w_match;
    logic [CHANNELS-1:0] w_lane_match;

    python_align_word_cmp #(
        .CHANNELS      (CHANNELS),
        .TRAIN_PATTERN (TRAIN_PATTERN)
    ) u_word_cmp (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_data       (in_data),
        .i_sync       (in_sync),
        .o_sync_match (w_sync_match),
        .o_lane_match (w_lane_match)
    );

    always_comb begin
        w_next = r_state;
        if (!enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next = ST_CHECK;
                ST_CHECK: begin
                    if (w_match) begin
                        if (r_match_cnt == MATCH_LAST) w_next = ST_LOCKED;
                    end else if (32'(r_slip_cnt) < MAX_SLIP) begin
                        w_next = ST_SLIP;
                    end else begin
                        w_next = ST_FAIL;
                    end
                end
                ST_SLIP:  w_next = ST_WAIT;
                ST_WAIT:  if (r_wait_cnt == 8'd0) w_next = ST_CHECK;
                default:  w_next = r_state;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the deciding edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_match_cnt <= 8'd0;
            r_wait_cnt  <= 8'd0;
            r_slip_cnt  <= 4'd0;
            r_bitslip   <= 1'b0;
            r_aligned   <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_bitslip <= (w_next == ST_SLIP);
            r_aligned <= (w_next == ST_LOCKED);
            r_error   <= (w_next == ST_FAIL);

            if (r_state == ST_IDLE && enable) begin
                r_match_cnt <= 8'd0;
                r_slip_cnt  <= 4'd0;
            end else if (r_state == ST_CHECK) begin
                r_match_cnt <= w_match ? r_match_cnt + 8'd1 : 8'd0;
                if (w_next == ST_SLIP && r_slip_cnt != SLIP_CNT_SAT) begin
                    r_slip_cnt <= r_slip_cnt + 4'd1;
                end
            end

            if (r_state == ST_SLIP) begin
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == ST_WAIT && r_wait_cnt != 8'd0) begin
                r_wait_cnt <= r_wait_cnt - 8'd1;
            end
        end
    end

`ifdef PYTHON_ALIGN_DATA_CHECK_EN
    logic [CHANNELS-1:0] r_ch_error;

    assign w_match = w_sync_match & (&w_lane_match);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch_error <= '0;
        end else if (r_state == ST_IDLE && enable) begin
            r_ch_error <= '0;
        end else if (r_state == ST_LOCKED && w_next == ST_LOCKED) begin
            r_ch_error <= r_ch_error | ~w_lane_match;
        end
    end

    assign out_ch_error = r_ch_error;
`else
    logic w_unused_lanes;

    assign w_unused_lanes = ^w_lane_match;
    assign w_match        = w_sync_match;
    assign out_ch_error   = '0;
`endif

    assign out_bitslip    = r_bitslip;
    assign out_aligned    = r_aligned;
    assign out_error      = r_error;
    assign out_slip_count = r_slip_cnt;

endmodule

// File: tb/tb_python_align_training.sv
// Scoreboard bench: a deserializer model drives the block, a training-rule model predicts events.
module tb_python_align_training;

    localparam int         CH     = 4;
    localparam logic [9:0] TRAIN  = 10'h3A6;
    localparam int         SW     = 8;
    localparam int         MC     = 16;
    localparam int         MAXS   = 10;

    localparam int EV_PULSE = 0;
    localparam int EV_ALIGN = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int kind;
        int cyc;
        int slips;
    } ev_t;

    logic                reset = 1'b1;
    logic                clk   = 1'b0;
    logic                enable = 1'b0;
    logic [CH-1:0][9:0]  in_data = '0;
    logic [9:0]          in_sync = '0;
    logic                out_bitslip, out_aligned, out_error;
    logic [3:0]          out_slip_count;
    logic [CH-1:0]       out_ch_error;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    ev_t  exp_q[$];

    // deserializer model state
    int   rot          = 0;
    bit   rot_on_slip  = 1'b1;
    bit   rand_mode    = 1'b0;
    int   glitch_cyc   = -1;
    int   lane_glitch  = -1;

    python_align_training #(
        .CHANNELS      (CH),
        .TRAIN_PATTERN (TRAIN),
        .SLIP_WAIT     (SW),
        .MATCH_COUNT   (MC),
        .MAX_SLIP      (MAXS)
    ) dut (
        .reset          (reset),
        .clk            (clk),
        .enable         (enable),
        .in_data        (in_data),
        .in_sync        (in_sync),
        .out_bitslip    (out_bitslip),
        .out_aligned    (out_aligned),
        .out_error      (out_error),
        .out_slip_count (out_slip_count),
        .out_ch_error   (out_ch_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] rotl10(input logic [9:0] w, input int r);
        logic [19:0] d;
        d = {w, w} << r;
        return d[19:10];
    endfunction

    // Training rules: each attempt either locks after MC matches or fails after m matches,
    // then slips (pulse on the failing decision) and resumes checking SW+2 cycles later.
    function automatic void push_model(input int e, input int bad_attempts,
                                       input int glitch_m, input bit never_match);
        int d;
        int slips;
        int m;
        d = e + 1;
        slips = 0;
        for (int k = 0; k < 64; k++) begin
            if (never_match || k < bad_attempts) m = 0;
            else if (k == 0 && glitch_m >= 0)     m = glitch_m;
            else                                  m = MC;
            if (m >= MC) begin
                exp_q.push_back('{EV_ALIGN, d + MC - 1, slips});
                return;
            end
            if (slips < MAXS) begin
                slips = (slips >= 15) ? 15 : slips + 1;
                exp_q.push_back('{EV_PULSE, d + m, slips});
                d = d + m + SW + 2;
            end else begin
                exp_q.push_back('{EV_ERR, d + m, slips});
                return;
            end
        end
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_event(input int kind);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d slips %0d, expected none",
                     kind, cyc, out_slip_count);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.slips != int'(out_slip_count)) begin
                n_fail++;
                $display("FAIL event: got kind %0d cycle %0d slips %0d, expected kind %0d cycle %0d slips %0d",
                         kind, cyc, out_slip_count, e.kind, e.cyc, e.slips);
            end
        end
    endtask

    // monitor
    initial begin
        bit prev_al;
        bit prev_er;
        prev_al = 1'b0;
        prev_er = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_bitslip)               check_event(EV_PULSE);
                if (out_aligned && !prev_al)   check_event(EV_ALIGN);
                if (out_error && !prev_er)     check_event(EV_ERR);
            end
            prev_al = out_aligned;
            prev_er = out_error;
        end
    end

    task automatic tick();
        logic [9:0] w;
        @(negedge clk);
        if (out_bitslip && rot_on_slip) rot = (rot + 9) % 10;
        if (rand_mode) begin
            do w = 10'($urandom); while (w == TRAIN);
            in_sync = w;
            for (int i = 0; i < CH; i++) in_data[i] = 10'($urandom);
        end else begin
            w = rotl10(TRAIN, rot);
            if (cyc + 1 == glitch_cyc) w = ~TRAIN;
            in_sync = w;
            for (int i = 0; i < CH; i++) in_data[i] = w;
            if (cyc + 1 == lane_glitch) in_data[2] = ~TRAIN;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d events still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        ticks(4);
    endtask

    task automatic start(output int e);
        tick();
        enable = 1'b1;
        e = cyc + 1;
    endtask

    task automatic stop();
        tick();
        enable = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int e;
        ticks(3);
        check("rst_bitslip", out_bitslip, 0);
        check("rst_aligned", out_aligned, 0);
        check("rst_error", out_error, 0);
        check("rst_slip_count", out_slip_count, 0);
        check("rst_ch_error", out_ch_error, 0);
        reset = 1'b0;
        ticks(3);
        check("idle_no_enable", out_aligned | out_error | out_bitslip, 0);

        // aligned from the first word
        rot = 0; rot_on_slip = 1'b1; rand_mode = 1'b0;
        start(e);
        push_model(e, 0, -1, 1'b0);
        wait_drain("lock_direct", 100);
        check("direct_slip_count", out_slip_count, 0);
        check("direct_aligned_held", out_aligned, 1);
        lane_glitch = cyc + 2;
        ticks(5);
`ifdef PYTHON_ALIGN_DATA_CHECK_EN
        check("lane2_ch_error", out_ch_error, 4'b0100);
`else
        check("lane2_ch_error", out_ch_error, 0);
`endif
        check("lane2_still_aligned", out_aligned, 1);
        lane_glitch = -1;
        stop();
        check("drop_aligned", out_aligned, 0);
        check("drop_bitslip", out_bitslip, 0);

        // rotated by 3, one rotation per slip
        rot = 3;
        start(e);
        push_model(e, 3, -1, 1'b0);
        wait_drain("lock_rot3", 200);
        check("rot3_slip_count", out_slip_count, 3);
        check("rot3_aligned", out_aligned, 1);
        stop();

        // mismatch on the 15th of 16 matches
        rot = 0; rot_on_slip = 1'b0;
        start(e);
        glitch_cyc = e + MC - 2;
        push_model(e, 0, MC - 2, 1'b0);
        wait_drain("glitch15", 200);
        check("glitch_slip_count", out_slip_count, 1);
        glitch_cyc = -1;
        stop();

        // never matching
        rand_mode = 1'b1;
        start(e);
        push_model(e, 0, -1, 1'b1);
        wait_drain("never_match", 400);
        check("fail_error", out_error, 1);
        check("fail_aligned", out_aligned, 0);
        check("fail_slip_count", out_slip_count, MAXS);
        stop();
        check("fail_drop_error", out_error, 0);
        check("fail_drop_aligned", out_aligned, 0);
        rand_mode = 1'b0;

        // reset in the middle of WAIT
        rot = 3; rot_on_slip = 1'b1;
        start(e);
        exp_q.push_back('{EV_PULSE, e + 1, 1});
        wait_drain("pre_reset", 50);
        reset = 1'b1;
        #1;
        check("wait_rst_bitslip", out_bitslip, 0);
        check("wait_rst_aligned", out_aligned, 0);
        check("wait_rst_error", out_error, 0);
        check("wait_rst_slip_count", out_slip_count, 0);
        check("wait_rst_ch_error", out_ch_error, 0);
        ticks(2);
        reset = 1'b0;
        e = cyc + 1;
        push_model(e, 2, -1, 1'b0);
        wait_drain("post_reset", 200);
        check("post_reset_slip_count", out_slip_count, 2);
        stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
